gpr_sb_rf: RTL and testbench
============================

Name: gpr_sb_rf

Overview:
- Next-generation general-purpose register file for the pipelined core.
- Generalised in width, depth and read-port count.
- Adds a second write port, write-to-read bypass, a per-register busy scoreboard for hazard detection, and asynchronous reset of all state.
- Sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH (4 gives RV32E).
- DATA_WIDTH, 32, register width.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads see registered contents only.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wen0  in  1  write port 0 enable (ALU writeback).
- waddr0  in  ADDR_WIDTH  write port 0 index.
- wdata0  in  DATA_WIDTH  write port 0 data.
- wen1  in  1  write port 1 enable (LSU writeback).
- waddr1  in  ADDR_WIDTH  write port 1 index.
- wdata1  in  DATA_WIDTH  write port 1 data.
- issue_en  in  1  mark issue_rd busy.
- issue_rd  in  ADDR_WIDTH  destination being issued.
- issue_ok  out  1  issue_rd may be issued this cycle.
- raddr  in  NREAD*ADDR_WIDTH  packed read indices, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NREAD*DATA_WIDTH  packed read data, same packing.
- rready  out  NREAD  operand i valid (not pending).
- busy  out  2**ADDR_WIDTH  scoreboard vector; bit 0 always 0.
- sb_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0.
  - busy clears to all 0.
  - sb_err clears to 0.
  - Outputs settle combinationally: rdata=0, rready=all 1, issue_ok=1.
- Register 0:
  - Reads always return 0 with rready=1.
  - Writes to index 0 are ignored.
  - issue_en with issue_rd=0 never sets busy.
- Writes:
  - Take effect at posedge when wenK=1 and waddrK!=0.
  - If both ports target the same nonzero index in one cycle, port 1 wins.
- Reads: combinational, zero latency.
  - BYPASS=1: if a write port targets raddr_i (nonzero) this cycle, rdata_i returns that write's data, with port 1 taking priority over port 0. Otherwise the stored value is returned.
  - BYPASS=0: stored value only.
- rready_i:
  - 1 if raddr_i==0, or busy[raddr_i]==0.
  - Also 1 if BYPASS=1 and some wenK targets raddr_i this cycle.
  - 0 otherwise.
- Scoreboard update at posedge, per nonzero index r:
  - set = issue_en && issue_ok && issue_rd==r
  - clr = (wen0 && waddr0==r) || (wen1 && waddr1==r)
  - set wins over clr: busy[r] stays/becomes 1.
  - clr alone: busy[r] becomes 0.
  - Otherwise busy[r] holds.
- issue_ok = (issue_rd==0) || !busy[issue_rd] || (a write port clears issue_rd this cycle).
- Protocol error:
  - issue_en && !issue_ok is a protocol error. busy is unchanged and sb_err is set at the next posedge.
  - sb_err holds until reset.
  - A write to a non-busy register is legal: data is written and busy is unaffected.
- Reset mid-operation: all pending busy bits are discarded; no writeback in the reset cycle takes effect.

Test Plan:
- Reset, then read every index on all ports -> rdata=0, rready all 1, busy=0, sb_err=0.
- wen0 waddr0=5 wdata0=0xDEADBEEF; next cycle raddr0=5 -> 0xDEADBEEF. Write 0x1234 to index 0 -> reading index 0 returns 0.
- Same cycle wen0 (7, 0x11) and wen1 (7, 0x22) with raddr1=7 -> BYPASS=1 gives 0x22 that cycle; stored value is 0x22 afterwards.
- issue_en rd=9 -> busy[9]=1 and rready=0 for raddr=9. Then wen1 waddr1=9 wdata=0xA5 -> same cycle rready=1 with rdata=0xA5 (BYPASS=1); busy[9]=0 next cycle.
- busy[3]=1; same cycle issue_en rd=3 plus wen0 waddr0=3 -> issue_ok=1 and busy[3] stays 1. Separately, issue_en rd=4 while busy[4]=1 and no write -> issue_ok=0, busy unchanged, sb_err=1 next cycle.
- Set busy[2], busy[6], sb_err=1; pulse rst_n low between edges -> immediately all registers 0, busy=0, sb_err=0.

Source files
------------

// File: rtl/gpr_sb_rf.sv
// General-purpose register file: two write ports, N combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module gpr_sb_rf #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wen0,
    input  logic [ADDR_WIDTH-1:0]          waddr0,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic                           wen1,
    input  logic [ADDR_WIDTH-1:0]          waddr1,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic                           issue_ok,
    input  logic [NREAD*ADDR_WIDTH-1:0]    raddr,
    output logic [NREAD*DATA_WIDTH-1:0]    rdata,
    output logic [NREAD-1:0]               rready,
    output logic [(1<<ADDR_WIDTH)-1:0]     busy,
    output logic                           sb_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic                  r_sb_err;

    logic                  w_wr0;
    logic                  w_wr1;
    logic                  w_issue_clr;
    logic [DEPTH-1:0]      w_busy_nxt;

    // Writes are suppressed while reset is asserted so nothing is forwarded either.
    assign w_wr0 = wen0 && rst_n && (waddr0 != '0);
    assign w_wr1 = wen1 && rst_n && (waddr1 != '0);

    assign w_issue_clr = (w_wr0 && (waddr0 == issue_rd)) || (w_wr1 && (waddr1 == issue_rd));
    assign issue_ok    = (issue_rd == '0) || !r_busy[issue_rd] || w_issue_clr;

    assign busy   = r_busy;
    assign sb_err = r_sb_err;

    // Storage update; port 1 assigned last so it wins on a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr0) r_regs[waddr0] <= wdata0;
            if (w_wr1) r_regs[waddr1] <= wdata1;
        end
    end

    // Writeback clears busy, a successful issue sets it; set applied last so it wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0) w_busy_nxt[waddr0] = 1'b0;
        if (w_wr1) w_busy_nxt[waddr1] = 1'b0;
        if (issue_en && issue_ok && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (issue_en && !issue_ok) r_sb_err <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd;
        logic                  w_rdy;

        assign w_ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux with port-1-over-port-0 forwarding; index 0 is hardwired zero.
        always_comb begin
            w_rd  = r_regs[w_ra];
            w_rdy = !r_busy[w_ra];
            if (BYPASS != 0) begin
                if (w_wr0 && (waddr0 == w_ra)) begin
                    w_rd  = wdata0;
                    w_rdy = 1'b1;
                end
                if (w_wr1 && (waddr1 == w_ra)) begin
                    w_rd  = wdata1;
                    w_rdy = 1'b1;
                end
            end
            if (w_ra == '0) begin
                w_rd  = '0;
                w_rdy = 1'b1;
            end
        end

        assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
        assign rready[gi]                         = w_rdy;
    end

endmodule

// File: tb/tb_gpr_sb_rf.sv
// Self-checking bench for gpr_sb_rf: directed vector table, hand-written
// hazard/reset sequences and randomized traffic against a behavioural model.
module tb_gpr_sb_rf;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wen0, wen1, issue_en;
    logic [AW-1:0]     waddr0, waddr1, issue_rd;
    logic [DW-1:0]     wdata0, wdata1;
    logic              issue_ok;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rready;
    logic [DEPTH-1:0]  busy;
    logic              sb_err;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    logic [DW-1:0]     m_mem [DEPTH];
    logic [DEPTH-1:0]  m_busy;
    logic              m_err;

    gpr_sb_rf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(issue_ok),
        .raddr(raddr), .rdata(rdata), .rready(rready),
        .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          ie;
        logic [AW-1:0] ir;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        logic [1:0]    e_rdy;
        logic          e_ok;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic ie, input logic [AW-1:0] ir,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wen0 = w0; waddr0 = a0; wdata0 = d0;
        wen1 = w1; waddr1 = a1; wdata1 = d1;
        issue_en = ie; issue_rd = ir;
        raddr = {ra1, ra0};
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, ra0, ra1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (wen1 && waddr1 == a) return wdata1;
        if (wen0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic exp_rready(input logic [AW-1:0] a);
        if (a == '0 || !m_busy[a]) return 1'b1;
        return (wen0 && waddr0 == a) || (wen1 && waddr1 == a);
    endfunction

    function automatic logic exp_issue_ok();
        return exp_rready(issue_rd);
    endfunction

    // One clock: the model absorbs the inputs present at the rising edge.
    task automatic cycle();
        logic ok;
        @(posedge clk);
        ok = exp_issue_ok();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (issue_en && !ok) m_err = 1'b1;
            if (wen0 && waddr0 != '0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (wen1 && waddr1 != '0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (issue_en && ok && issue_rd != '0) m_busy[issue_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        for (int p = 0; p < int'(NR); p++) begin
            logic [AW-1:0] a;
            a = raddr[p*AW +: AW];
            chk($sformatf("%s rdata%0d", tag, p), 64'(rdata[p*DW +: DW]), 64'(exp_rdata(a)));
            chk($sformatf("%s rready%0d", tag, p), 64'(rready[p]), 64'(exp_rready(a)));
        end
        chk({tag, " issue_ok"}, 64'(issue_ok), 64'(exp_issue_ok()));
        chk({tag, " busy"}, 64'(busy), 64'(m_busy));
        chk({tag, " sb_err"}, 64'(sb_err), 64'(m_err));
    endtask

    initial begin
        tbl[0] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd31, 32'h0,        32'h0,        2'b11, 1'b1};
        tbl[1] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        2'b11, 1'b1};
        tbl[2] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        2'b11, 1'b1};
        tbl[3] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd0, 5'd7,  32'h0,        32'h22,       2'b11, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd5,  32'h22,       32'hDEADBEEF, 2'b11, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd7,  32'h0,        32'h22,       2'b11, 1'b1};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd9, 5'd9, 5'd0,  32'h0,        32'h0,        2'b10, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hA5, 1'b0, 5'd0, 5'd9, 5'd9,  32'hA5,       32'hA5,       2'b11, 1'b1};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0,  32'hA5,       32'h0,        2'b11, 1'b1};

        // Reset state, every index on both ports
        model_reset();
        idle('0, '0);
        #2;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idle(AW'(i), AW'(DEPTH - 1 - i));
            #1;
            chk($sformatf("reset rdata idx%0d", i), 64'(rdata), 64'(0));
            chk($sformatf("reset rready idx%0d", i), 64'(rready), 64'(2'b11));
        end
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset sb_err", 64'(sb_err), 64'(0));
        chk("reset issue_ok", 64'(issue_ok), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 9; v++) begin
            drive(tbl[v].w0, tbl[v].a0, tbl[v].d0, tbl[v].w1, tbl[v].a1, tbl[v].d1,
                  tbl[v].ie, tbl[v].ir, tbl[v].ra0, tbl[v].ra1);
            #1;
            chk($sformatf("vec%0d rdata0", v), 64'(rdata[DW-1:0]), 64'(tbl[v].e_rd0));
            chk($sformatf("vec%0d rdata1", v), 64'(rdata[2*DW-1:DW]), 64'(tbl[v].e_rd1));
            chk($sformatf("vec%0d rready", v), 64'(rready), 64'(tbl[v].e_rdy));
            chk($sformatf("vec%0d issue_ok", v), 64'(issue_ok), 64'(tbl[v].e_ok));
            cycle();
        end
        idle('0, '0);
        #1;
        chk("table busy", 64'(busy), 64'(0));
        chk("table sb_err", 64'(sb_err), 64'(0));

        // Set wins over clear on the same index
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, '0, '0);
        cycle();
        drive(1'b1, 5'd3, 32'h77, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, '0);
        #1;
        chk("setclr issue_ok", 64'(issue_ok), 64'(1));
        chk("setclr rdata", 64'(rdata[DW-1:0]), 64'(32'h77));
        cycle();
        idle(5'd3, '0);
        #1;
        chk("setclr busy", 64'(busy), 64'(32'h8));
        chk("setclr sb_err", 64'(sb_err), 64'(0));
        chk("setclr rready", 64'(rready), 64'(2'b10));

        // Issue to a busy register without writeback is a protocol error
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, '0, '0);
        #1;
        chk("err issue_ok", 64'(issue_ok), 64'(0));
        cycle();
        idle('0, '0);
        #1;
        chk("err busy", 64'(busy), 64'(32'h18));
        chk("err sb_err", 64'(sb_err), 64'(1));

        // Asynchronous reset mid-operation, writeback held through the reset edge
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd2, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd6, '0, '0);
        cycle();
        idle('0, '0);
        #1;
        chk("pre-rst busy", 64'(busy), 64'(32'h5C));
        drive(1'b1, 5'd5, 32'hFFFF, 1'b0, '0, '0, 1'b0, 5'd6, 5'd5, 5'd7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst sb_err", 64'(sb_err), 64'(0));
        chk("rst rdata", 64'(rdata), 64'(0));
        chk("rst rready", 64'(rready), 64'(2'b11));
        chk("rst issue_ok", 64'(issue_ok), 64'(1));
        cycle();
        idle(5'd5, 5'd7);
        rst_n = 1'b1;
        #1;
        chk("post-rst rdata", 64'(rdata), 64'(0));
        chk("post-rst busy", 64'(busy), 64'(0));

        // Randomized traffic against the model, with reset pulses between blocks
        for (int blk = 0; blk < 3; blk++) begin
            for (int n = 0; n < 600; n++) begin
                logic [AW-1:0] ra0, ra1, a0, a1, ir;
                bit wide;
                wide = ($urandom_range(0, 7) == 0);
                a0  = wide ? AW'($urandom) : AW'($urandom_range(0, 7));
                a1  = AW'($urandom_range(0, 7));
                ir  = wide ? AW'($urandom) : AW'($urandom_range(0, 7));
                ra0 = AW'($urandom_range(0, 7));
                ra1 = wide ? AW'($urandom) : AW'($urandom_range(0, 7));
                drive($urandom_range(0, 2) == 0, a0, DW'($urandom),
                      $urandom_range(0, 2) == 0, a1, DW'($urandom),
                      $urandom_range(0, 3) == 0, ir, ra0, ra1);
                #1;
                check_model($sformatf("rand b%0d c%0d", blk, n));
                cycle();
            end
            idle('0, '0);
            rst_n = 1'b0;
            #1;
            model_reset();
            chk($sformatf("rand b%0d reset busy", blk), 64'(busy), 64'(0));
            cycle();
            rst_n = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
